// File: rtl/ipr1_trigmot_seq_if.sv
// rtl/ipr1_trigmot_seq_if.sv - host event handshake bundle for the motion-trigger sequencer
//
// Purpose: carries the host-facing event interface of ipr1_trigmot_seq.
// Signals:
//   event_o      level, event pending until acknowledged
//   event_ack_i  host acknowledge
//   overrun_o    sticky, an event fired while the previous one was still pending
//   event_cnt_o  events since enable rose (wraps)
//   cogx_o .. bottom_o  COG / bounding-box results latched at the accepted event
// Modports: master = sequencer side, slave = host side.
interface ipr1_trigmot_seq_if #(
   parameter int CNT_W = 16
);
   logic             event_o;
   logic             event_ack_i;
   logic             overrun_o;
   logic [CNT_W-1:0] event_cnt_o;
   logic [7:0]       cogx_o;
   logic [7:0]       cogy_o;
   logic [7:0]       left_o;
   logic [7:0]       right_o;
   logic [7:0]       top_o;
   logic [7:0]       bottom_o;

   modport master (
      output event_o, overrun_o, event_cnt_o,
      output cogx_o, cogy_o, left_o, right_o, top_o, bottom_o,
      input  event_ack_i
   );

   modport slave (
      input  event_o, overrun_o, event_cnt_o,
      input  cogx_o, cogy_o, left_o, right_o, top_o, bottom_o,
      output event_ack_i
   );
endinterface

// File: rtl/ipr1_trigmot_seq.sv
// rtl/ipr1_trigmot_seq.sv - frame-level sequencer for the IPR1 motion-trigger datapath
//
// Purpose: gates whole sensor frames into the datapath, skips warm-up frames, qualifies the
// per-frame trigger by persistence, latches results on an event and applies a hold-off.
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   enable                            host run enable
//   warmup_frames / persist_frames / holdoff_frames   frame counts (persist 0 acts as 1)
//   frame_valid_i, data_valid_i, pixel_i              sensor stream
//   dp_frame_valid_o, dp_data_valid_o, dp_pixel_o     gated, registered stream to datapath
//   trig_i, cogx_i .. bottom_i        datapath trigger and results, sampled SAMPLE_DLY after frame end
//   state_o                           0 IDLE, 1 WARMUP, 2 ARMED, 3 HOLDOFF
//   host                              event / ack / overrun / counter / latched results
module ipr1_trigmot_seq #(
   parameter int SAMPLE_DLY = 4,
   parameter int CNT_W      = 16
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       enable,
   input  logic [3:0] warmup_frames,
   input  logic [3:0] persist_frames,
   input  logic [7:0] holdoff_frames,
   input  logic       frame_valid_i,
   input  logic       data_valid_i,
   input  logic [7:0] pixel_i,
   output logic       dp_frame_valid_o,
   output logic       dp_data_valid_o,
   output logic [7:0] dp_pixel_o,
   input  logic       trig_i,
   input  logic [7:0] cogx_i,
   input  logic [7:0] cogy_i,
   input  logic [7:0] left_i,
   input  logic [7:0] right_i,
   input  logic [7:0] top_i,
   input  logic [7:0] bottom_i,
   output logic [1:0] state_o,
   ipr1_trigmot_seq_if.master host
);

   localparam int DLY_W = $clog2(SAMPLE_DLY + 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WARMUP  = 2'd1,
      S_ARMED   = 2'd2,
      S_HOLDOFF = 2'd3
   } state_t;

   state_t           state, state_n;
   logic [3:0]       wcnt, wcnt_n, pcnt, pcnt_n;
   logic [7:0]       hcnt, hcnt_n;
   logic             fire;
   logic             fv_d, gate, en_d;
   logic [DLY_W-1:0] dcnt;
   logic             frame_rise, gate_now, frame_end, strobe, en_rise;
   logic [3:0]       pmax;
   logic             event_q, overrun_q;
   logic [CNT_W-1:0] evt_cnt;
   logic [47:0]      res_q;

   // The gate decision is taken only on the first cycle of a frame, so frames are all-or-nothing.
   assign frame_rise = frame_valid_i & ~fv_d;
   assign gate_now   = frame_rise ? enable : gate;
   assign frame_end  = fv_d & ~frame_valid_i & gate;
   assign strobe     = (dcnt == DLY_W'(1));
   assign en_rise    = enable & ~en_d;
   assign pmax       = (persist_frames == 4'd0) ? 4'd1 : persist_frames;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fv_d             <= 1'b0;
         gate             <= 1'b0;
         en_d             <= 1'b0;
         dcnt             <= '0;
         dp_frame_valid_o <= 1'b0;
         dp_data_valid_o  <= 1'b0;
         dp_pixel_o       <= 8'd0;
      end else begin
         fv_d             <= frame_valid_i;
         gate             <= frame_valid_i ? gate_now : 1'b0;
         en_d             <= enable;
         dp_pixel_o       <= pixel_i;
         dp_frame_valid_o <= frame_valid_i & gate_now;
         dp_data_valid_o  <= data_valid_i & frame_valid_i & gate_now;
         // A later frame end restarts the delay; the earlier sample is dropped.
         if (frame_end)
            dcnt <= DLY_W'(SAMPLE_DLY);
         else if (dcnt != '0)
            dcnt <= dcnt - DLY_W'(1);
      end
   end

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
         wcnt  <= 4'd0;
         pcnt  <= 4'd0;
         hcnt  <= 8'd0;
      end else begin
         state <= state_n;
         wcnt  <= wcnt_n;
         pcnt  <= pcnt_n;
         hcnt  <= hcnt_n;
      end
   end

   // Next-state logic
   always_comb begin
      state_n = state;
      wcnt_n  = wcnt;
      pcnt_n  = pcnt;
      hcnt_n  = hcnt;
      fire    = 1'b0;
      if (!enable) begin
         state_n = S_IDLE;
         wcnt_n  = 4'd0;
         pcnt_n  = 4'd0;
         hcnt_n  = 8'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (en_rise) begin
                  wcnt_n  = 4'd0;
                  pcnt_n  = 4'd0;
                  state_n = (warmup_frames == 4'd0) ? S_ARMED : S_WARMUP;
               end
            end
            S_WARMUP: begin
               if (strobe) begin
                  wcnt_n = wcnt + 4'd1;
                  if (wcnt_n == warmup_frames) begin
                     state_n = S_ARMED;
                     wcnt_n  = 4'd0;
                     pcnt_n  = 4'd0;
                  end
               end
            end
            S_ARMED: begin
               if (strobe) begin
                  if (trig_i) begin
                     pcnt_n = pcnt + 4'd1;
                     if (pcnt_n == pmax) begin
                        fire    = 1'b1;
                        pcnt_n  = 4'd0;
                        hcnt_n  = 8'd0;
                        state_n = (holdoff_frames == 8'd0) ? S_ARMED : S_HOLDOFF;
                     end
                  end else begin
                     pcnt_n = 4'd0;
                  end
               end
            end
            default: begin
               if (strobe) begin
                  hcnt_n = hcnt + 8'd1;
                  if (hcnt_n == holdoff_frames) begin
                     state_n = S_ARMED;
                     hcnt_n  = 8'd0;
                  end
               end
            end
         endcase
      end
   end

   // Output logic
   always_comb begin
      state_o = state;
   end

   // Event handshake. A fire in the same cycle as an ack is treated as a fresh event.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         event_q   <= 1'b0;
         overrun_q <= 1'b0;
         evt_cnt   <= '0;
         res_q     <= 48'd0;
      end else begin
         if (en_rise) begin
            overrun_q <= 1'b0;
            evt_cnt   <= '0;
         end
         if (fire) begin
            evt_cnt <= evt_cnt + CNT_W'(1);
            if (!event_q || host.event_ack_i) begin
               res_q   <= {cogx_i, cogy_i, left_i, right_i, top_i, bottom_i};
               event_q <= 1'b1;
            end else begin
               overrun_q <= 1'b1;
            end
         end else if (host.event_ack_i) begin
            event_q <= 1'b0;
         end
      end
   end

   assign host.event_o     = event_q;
   assign host.overrun_o   = overrun_q;
   assign host.event_cnt_o = evt_cnt;
   assign host.cogx_o      = res_q[47:40];
   assign host.cogy_o      = res_q[39:32];
   assign host.left_o      = res_q[31:24];
   assign host.right_o     = res_q[23:16];
   assign host.top_o       = res_q[15:8];
   assign host.bottom_o    = res_q[7:0];

endmodule

// File: tb/tb_ipr1_trigmot_seq.sv
// tb/tb_ipr1_trigmot_seq.sv - randomized self-checking bench for ipr1_trigmot_seq
//
// Purpose: drives random frames, trigger patterns, acks and enable changes, and compares the
// sequencer against a frame-level reference model.
module tb_ipr1_trigmot_seq;

   localparam int SAMPLE_DLY = 4;
   localparam int CNT_W      = 16;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       enable;
   logic [3:0] warmup_frames;
   logic [3:0] persist_frames;
   logic [7:0] holdoff_frames;
   logic       frame_valid_i;
   logic       data_valid_i;
   logic [7:0] pixel_i;
   logic       dp_frame_valid_o;
   logic       dp_data_valid_o;
   logic [7:0] dp_pixel_o;
   logic       trig_i;
   logic [7:0] cogx_i, cogy_i, left_i, right_i, top_i, bottom_i;
   logic [1:0] state_o;

   ipr1_trigmot_seq_if #(.CNT_W(CNT_W)) host ();

   ipr1_trigmot_seq #(.SAMPLE_DLY(SAMPLE_DLY), .CNT_W(CNT_W)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .enable           (enable),
      .warmup_frames    (warmup_frames),
      .persist_frames   (persist_frames),
      .holdoff_frames   (holdoff_frames),
      .frame_valid_i    (frame_valid_i),
      .data_valid_i     (data_valid_i),
      .pixel_i          (pixel_i),
      .dp_frame_valid_o (dp_frame_valid_o),
      .dp_data_valid_o  (dp_data_valid_o),
      .dp_pixel_o       (dp_pixel_o),
      .trig_i           (trig_i),
      .cogx_i           (cogx_i),
      .cogy_i           (cogy_i),
      .left_i           (left_i),
      .right_i          (right_i),
      .top_i            (top_i),
      .bottom_i         (bottom_i),
      .state_o          (state_o),
      .host             (host)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: frame-level bookkeeping
   logic        m_en = 1'b0;
   int          m_warm_left = 0;
   int          m_run = 0;
   int          m_hold_left = 0;
   logic        m_pend = 1'b0;
   logic        m_ovr = 1'b0;
   logic [15:0] m_cnt = 16'd0;
   logic [47:0] m_res = 48'd0;
   logic        cur_gated = 1'b0;
   logic        last_fv = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [1:0] m_state();
      if (!m_en)              return 2'd0;
      else if (m_warm_left > 0) return 2'd1;
      else if (m_hold_left > 0) return 2'd3;
      else                      return 2'd2;
   endfunction

   task automatic check_status(input string tag);
      check({tag, ".state"}, 64'(state_o), 64'(m_state()));
      check({tag, ".event"}, 64'(host.event_o), 64'(m_pend));
      check({tag, ".overrun"}, 64'(host.overrun_o), 64'(m_ovr));
      check({tag, ".event_cnt"}, 64'(host.event_cnt_o), 64'(m_cnt));
      check({tag, ".results"}, 64'({host.cogx_o, host.cogy_o, host.left_o, host.right_o,
                                     host.top_o, host.bottom_o}), 64'(m_res));
   endtask

   task automatic set_res(input logic [47:0] r);
      {cogx_i, cogy_i, left_i, right_i, top_i, bottom_i} = r;
   endtask

   // One clock: drive at the negedge, check the registered pixel path at the next negedge.
   task automatic cyc(input logic fv, input logic dv, input logic [7:0] px);
      if (fv && !last_fv) cur_gated = enable;
      last_fv       = fv;
      frame_valid_i = fv;
      data_valid_i  = dv;
      pixel_i       = px;
      @(posedge clk);
      @(negedge clk);
      check("dp_path", 64'({dp_frame_valid_o, dp_data_valid_o, dp_pixel_o}),
            64'({fv & cur_gated, dv & fv & cur_gated, px}));
   endtask

   task automatic set_en(input logic v);
      if (v != m_en) begin
         if (v) begin
            m_ovr       = 1'b0;
            m_cnt       = 16'd0;
            m_warm_left = int'(warmup_frames);
         end else begin
            m_warm_left = 0;
         end
         m_run       = 0;
         m_hold_left = 0;
      end
      m_en   = v;
      enable = v;
   endtask

   task automatic model_strobe(input logic trg, input logic ack, input logic [47:0] res,
                               input logic counted);
      logic fire;
      int   pm;
      fire = 1'b0;
      pm   = (persist_frames == 4'd0) ? 1 : int'(persist_frames);
      if (counted) begin
         if (m_warm_left > 0) m_warm_left--;
         else if (m_hold_left > 0) m_hold_left--;
         else begin
            m_run = trg ? m_run + 1 : 0;
            if (m_run >= pm) begin
               fire        = 1'b1;
               m_run       = 0;
               m_hold_left = int'(holdoff_frames);
            end
         end
      end
      if (fire) begin
         m_cnt = m_cnt + 16'd1;
         if (!m_pend || ack) begin
            m_res  = res;
            m_pend = 1'b1;
         end else begin
            m_ovr = 1'b1;
         end
      end else if (ack) begin
         m_pend = 1'b0;
      end
   endtask

   // ack_mode: 0 none, 1 pulse mid-frame, 2 ack on the sample-strobe cycle
   task automatic run_frame(input logic trg, input int ack_mode, input logic tog);
      int          len, ackpos, togpos, gap;
      logic [47:0] res;
      len    = int'($urandom_range(3, 8));
      ackpos = int'($urandom_range(0, len - 1));
      togpos = int'($urandom_range(1, len - 1));
      for (int i = 0; i < len; i++) begin
         if (tog && i == togpos) set_en(!m_en);
         host.event_ack_i = (ack_mode == 1 && i == ackpos);
         trig_i = 1'($urandom);
         set_res(48'({$urandom, $urandom}));
         cyc(1'b1, 1'($urandom), 8'($urandom));
         if (host.event_ack_i) m_pend = 1'b0;
         if (tog && i == togpos) check("en_toggle.state", 64'(state_o), 64'(m_state()));
      end
      host.event_ack_i = 1'b0;
      res    = 48'({$urandom, $urandom});
      trig_i = trg;
      set_res(res);
      for (int k = 0; k < SAMPLE_DLY; k++) cyc(1'b0, 1'b0, 8'($urandom));
      check_status("pre_strobe");
      host.event_ack_i = (ack_mode == 2);
      cyc(1'b0, 1'b0, 8'($urandom));
      host.event_ack_i = 1'b0;
      model_strobe(trg, ack_mode == 2, res, m_en && cur_gated);
      check_status("strobe");
      trig_i = 1'($urandom);
      set_res(48'({$urandom, $urandom}));
      gap = int'($urandom_range(0, 2));
      for (int k = 0; k < gap; k++) cyc(1'b0, 1'b0, 8'($urandom));
   endtask

   initial begin
      reset_n          = 1'b0;
      enable           = 1'b0;
      warmup_frames    = 4'd0;
      persist_frames   = 4'd0;
      holdoff_frames   = 8'd0;
      frame_valid_i    = 1'b0;
      data_valid_i     = 1'b0;
      pixel_i          = 8'd0;
      trig_i           = 1'b0;
      host.event_ack_i = 1'b0;
      set_res(48'd0);
      repeat (3) @(negedge clk);
      check_status("reset");
      check("reset.dp", 64'({dp_frame_valid_o, dp_data_valid_o, dp_pixel_o}), 64'd0);
      reset_n = 1'b1;
      cyc(1'b0, 1'b0, 8'h00);
      check_status("post_reset");

      for (int seg = 0; seg < 10; seg++) begin
         warmup_frames  = 4'($urandom_range(0, 3));
         persist_frames = 4'($urandom_range(0, 3));
         holdoff_frames = 8'($urandom_range(0, 3));
         set_en(1'b1);
         cyc(1'b0, 1'b0, 8'($urandom));
         check_status("enable_rise");
         for (int f = 0, nf = int'($urandom_range(6, 14)); f < nf; f++) begin
            run_frame($urandom_range(0, 99) < 70, int'($urandom_range(0, 2)),
                      $urandom_range(0, 99) < 10);
         end
         set_en(1'b0);
         cyc(1'b0, 1'b0, 8'($urandom));
         check_status("disable");
      end

      // Asynchronous reset in the middle of a frame while in HOLDOFF
      warmup_frames  = 4'd0;
      persist_frames = 4'd1;
      holdoff_frames = 8'd10;
      set_en(1'b1);
      cyc(1'b0, 1'b0, 8'h00);
      run_frame(1'b1, 0, 1'b0);
      check("holdoff_entry.state", 64'(state_o), 64'd3);
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 8'($urandom));
      #2;
      reset_n = 1'b0;
      set_en(1'b0);
      #1;
      m_pend = 1'b0;
      m_ovr  = 1'b0;
      m_cnt  = 16'd0;
      m_res  = 48'd0;
      check_status("async_reset");
      check("async_reset.dp", 64'({dp_frame_valid_o, dp_data_valid_o, dp_pixel_o}), 64'd0);
      @(negedge clk);
      frame_valid_i = 1'b0;
      last_fv       = 1'b0;
      cur_gated     = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b0, 8'($urandom));
         check_status("reset_release_idle");
      end
      warmup_frames = 4'd2;
      set_en(1'b1);
      cyc(1'b0, 1'b0, 8'h00);
      check_status("reenable");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
